// File: rtl/sad_pkg.sv
// Shared state type and sizing helpers for the SAD window scorer.
package sad_pkg;

  localparam int PIX_W_DEFAULT = 8;

  typedef enum logic {IDLE, ACCUM} state_t;

  // Width that holds rows*cols unsigned pixel differences without overflow.
  function automatic int sad_width(input int pix_w, input int rows, input int cols);
    return pix_w + $clog2(rows * cols);
  endfunction

endpackage

// File: rtl/sad_col_abs_sum.sv
// Combinational column SAD: sum over ROWS lanes of |frame - tmpl|.
module sad_col_abs_sum
  import sad_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEFAULT,
  parameter int ROWS  = 4,
  parameter int COL_W = sad_width(PIX_W, ROWS, 1)
) (
  input  logic [ROWS*PIX_W-1:0] frame,
  input  logic [ROWS*PIX_W-1:0] tmpl,
  output logic [COL_W-1:0]      sum
);

  always_comb begin
    logic [PIX_W-1:0] f;
    logic [PIX_W-1:0] t;
    sum = '0;
    for (int r = 0; r < ROWS; r++) begin
      f = frame[r*PIX_W +: PIX_W];
      t = tmpl[r*PIX_W +: PIX_W];
      sum = sum + COL_W'((f >= t) ? (f - t) : (t - f));
    end
  end

endmodule

// File: rtl/sad_window_scorer.sv
// Per-window-position SAD accumulator with running minimum tracker.
// Define SAD_PIPE_EN to register the column SAD before accumulation (+1 cycle result latency).
module sad_window_scorer
  import sad_pkg::*;
#(
  parameter int PIX_W   = PIX_W_DEFAULT,
  parameter int ROWS    = 4,
  parameter int WIN_W   = 4,
  parameter int NUM_POS = 16,
  parameter int SAD_W   = sad_width(PIX_W, ROWS, WIN_W)
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Start,
  input  logic                  PixValid,
  input  logic [ROWS*PIX_W-1:0] FramePix,
  input  logic [ROWS*PIX_W-1:0] TmplPix,
  output logic                  Busy,
  output logic                  SadValid,
  output logic [SAD_W-1:0]      SadOut,
  output logic [7:0]            SadIdx,
  output logic [SAD_W-1:0]      MinSad,
  output logic [7:0]            MinIdx,
  output logic                  Done
);

  localparam int                COL_W     = sad_width(PIX_W, ROWS, 1);
  localparam int                BEAT_W    = (WIN_W > 1) ? $clog2(WIN_W) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WIN_W - 1);
  localparam logic [7:0]        LAST_POS  = 8'(NUM_POS - 1);

  state_t            state, state_next;
  logic [BEAT_W-1:0] beat, in_beat;
  logic [7:0]        pos, in_pos;
  logic              inputs_done, accept;
  logic [COL_W-1:0]  col_sad;
  logic [SAD_W-1:0]  acc, sum, min_base;
  logic              s_fire, s_first, s_last, finish;
  logic [7:0]        s_pos;
  logic [COL_W-1:0]  s_col;

  sad_col_abs_sum #(.PIX_W(PIX_W), .ROWS(ROWS), .COL_W(COL_W)) u_col (
    .frame (FramePix),
    .tmpl  (TmplPix),
    .sum   (col_sad)
  );

  // A Start-coincident beat is beat 0 of position 0 regardless of old counters.
  assign in_beat = Start ? '0 : beat;
  assign in_pos  = Start ? '0 : pos;
  assign accept  = PixValid && (Start || (state == ACCUM && !inputs_done));

`ifdef SAD_PIPE_EN
  logic             col_vld, col_first, col_last;
  logic [7:0]       col_pos;
  logic [COL_W-1:0] col_q;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      col_vld   <= 1'b0;
      col_first <= 1'b0;
      col_last  <= 1'b0;
      col_pos   <= '0;
      col_q     <= '0;
    end else begin
      col_vld   <= accept;
      col_first <= (in_beat == '0);
      col_last  <= (in_beat == LAST_BEAT);
      col_pos   <= in_pos;
      col_q     <= col_sad;
    end
  end

  // Start discards whatever beat of the old search sits in the pipe stage.
  assign s_fire  = col_vld && !Start;
  assign s_first = col_first;
  assign s_last  = col_last;
  assign s_pos   = col_pos;
  assign s_col   = col_q;
`else
  assign s_fire  = accept;
  assign s_first = (in_beat == '0);
  assign s_last  = (in_beat == LAST_BEAT);
  assign s_pos   = in_pos;
  assign s_col   = col_sad;
`endif

  assign finish   = s_fire && s_last && (s_pos == LAST_POS);
  assign sum      = (s_first ? '0 : acc) + SAD_W'(s_col);
  assign min_base = Start ? '1 : MinSad;
  assign Busy     = (state == ACCUM);

  always_ff @(posedge Clk) begin
    if (Rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (Start)  state_next = ACCUM;
    if (finish) state_next = IDLE;
  end

  // The position counter parks on the last index; inputs_done blocks further beats.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      beat        <= '0;
      pos         <= '0;
      inputs_done <= 1'b0;
    end else if (accept) begin
      inputs_done <= 1'b0;
      if (in_beat == LAST_BEAT) begin
        beat <= '0;
        if (in_pos == LAST_POS) begin
          pos         <= in_pos;
          inputs_done <= 1'b1;
        end else begin
          pos <= in_pos + 8'd1;
        end
      end else begin
        beat <= in_beat + BEAT_W'(1);
        pos  <= in_pos;
      end
    end else if (Start) begin
      beat        <= '0;
      pos         <= '0;
      inputs_done <= 1'b0;
    end
  end

  // Position 0 always replaces so the tracker never depends on the all-ones seed.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      acc      <= '0;
      SadValid <= 1'b0;
      SadOut   <= '0;
      SadIdx   <= '0;
      MinSad   <= '1;
      MinIdx   <= '0;
      Done     <= 1'b0;
    end else begin
      SadValid <= 1'b0;
      Done     <= 1'b0;
      if (Start) begin
        acc    <= '0;
        MinSad <= '1;
        MinIdx <= '0;
      end
      if (s_fire) begin
        acc <= sum;
        if (s_last) begin
          SadValid <= 1'b1;
          SadOut   <= sum;
          SadIdx   <= s_pos;
          if (sum < min_base || s_pos == '0) begin
            MinSad <= sum;
            MinIdx <= s_pos;
          end
          Done <= (s_pos == LAST_POS);
        end
      end
    end
  end

endmodule
